// File: rtl/datapath_sequencer_pkg.sv
// Shared definitions for the datapath sequencer: instruction layout, kind codes,
// buffer-control codes, FSM states and the ALU opcodes used by the datapath.
package datapath_sequencer_pkg;

    localparam int unsigned INSTR_W = 20;
    localparam int unsigned REG_W   = 4;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned BUFF_W  = 4;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned IMM_W   = 14;
    localparam int unsigned CNT_W   = 4;

    localparam logic [OP_W-1:0] ALU_AND = 4'h0;
    localparam logic [OP_W-1:0] ALU_OR  = 4'h1;
    localparam logic [OP_W-1:0] ALU_ADD = 4'h2;
    localparam logic [OP_W-1:0] ALU_SUB = 4'h3;
    localparam logic [OP_W-1:0] ALU_XOR = 4'h4;

    localparam logic [BUFF_W-1:0] BUFF_IDLE = 4'b0000;
    localparam logic [BUFF_W-1:0] BUFF_IMM  = 4'b0001;
    localparam logic [BUFF_W-1:0] BUFF_ALU  = 4'b1110;

    typedef enum logic [1:0] {
        KIND_NOP  = 2'b00,
        KIND_ALU  = 2'b01,
        KIND_MOVI = 2'b10,
        KIND_HALT = 2'b11
    } kind_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_HALTED = 3'd4
    } state_e;

    // Micro-instruction layout, MSB first: [19:18] kind ... [1:0] rsvd
    typedef struct packed {
        kind_e             kind;
        logic [REG_W-1:0]  rd;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [OP_W-1:0]   alu_op;
        logic [1:0]        rsvd;
    } instr_t;

endpackage

// File: rtl/dp_instr_decode.sv
// Combinational field extraction and reserved-bit check for one micro-instruction.
module dp_instr_decode
    import datapath_sequencer_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output kind_e              kind_c,
    output logic [REG_W-1:0]   rd_c,
    output logic [REG_W-1:0]   rs_c,
    output logic [REG_W-1:0]   rt_c,
    output logic [OP_W-1:0]    alu_op_c,
    output logic [DATA_W-1:0]  imm_c,
    output logic               illegal_c
);

    instr_t fields;

    assign fields   = instr_t'(instr);
    assign kind_c   = fields.kind;
    assign rd_c     = fields.rd;
    assign rs_c     = fields.rs;
    assign rt_c     = fields.rt;
    assign alu_op_c = fields.alu_op;
    assign imm_c    = DATA_W'(instr[IMM_W-1:0]);

    // MOVI's immediate spans the rsvd bits, so only the other kinds are checked
    assign illegal_c = (fields.kind != KIND_MOVI) && (fields.rsvd != 2'b00);

endmodule

// File: rtl/datapath_sequencer.sv
// Micro-instruction sequencer: accepts one instruction per handshake and issues
// registered regfile selects, ALU opcode, buffer control and immediate to the datapath.
module datapath_sequencer
    import datapath_sequencer_pkg::*;
#(
    parameter int unsigned EXEC_CYCLES = 1,
    parameter int unsigned RETIRE_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [INSTR_W-1:0]  instr,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic                resume,
    output logic [DATA_W-1:0]   initialR,
    output logic [REG_W-1:0]    regWrite,
    output logic [REG_W-1:0]    regRead1,
    output logic [REG_W-1:0]    regRead2,
    output logic [OP_W-1:0]     ALUOp,
    output logic [BUFF_W-1:0]   buffCtrl,
    output logic                regWriteEn,
    output logic                halted,
    output logic                illegal,
    output logic [RETIRE_W-1:0] retired
);

    kind_e              dec_kind;
    logic [REG_W-1:0]   dec_rd;
    logic [REG_W-1:0]   dec_rs;
    logic [REG_W-1:0]   dec_rt;
    logic [OP_W-1:0]    dec_alu_op;
    logic [DATA_W-1:0]  dec_imm;
    logic               dec_illegal;

    dp_instr_decode u_decode (
        .instr     (instr),
        .kind_c    (dec_kind),
        .rd_c      (dec_rd),
        .rs_c      (dec_rs),
        .rt_c      (dec_rt),
        .alu_op_c  (dec_alu_op),
        .imm_c     (dec_imm),
        .illegal_c (dec_illegal)
    );

    state_e              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [REG_W-1:0]    rd_q, rd_n;
    logic [DATA_W-1:0]   initialR_n;
    logic [REG_W-1:0]    regWrite_n, regRead1_n, regRead2_n;
    logic [OP_W-1:0]     ALUOp_n;
    logic [BUFF_W-1:0]   buffCtrl_n;
    logic                regWriteEn_n, halted_n, illegal_n, instr_ready_n;
    logic [RETIRE_W-1:0] retired_n;
    logic                accept_c;

    assign accept_c = instr_valid && instr_ready;

    // Next state plus next value of every registered output
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        rd_n         = rd_q;
        initialR_n   = initialR;
        regWrite_n   = regWrite;
        regRead1_n   = regRead1;
        regRead2_n   = regRead2;
        ALUOp_n      = ALUOp;
        buffCtrl_n   = BUFF_IDLE;
        regWriteEn_n = 1'b0;
        illegal_n    = 1'b0;
        retired_n    = retired;

        unique case (state)
            ST_IDLE: begin
                if (accept_c) begin
                    if (dec_illegal) begin
                        illegal_n = 1'b1;
                    end else begin
                        unique case (dec_kind)
                            KIND_NOP: retired_n = retired + RETIRE_W'(1);
                            KIND_ALU: begin
                                state_n    = ST_READ;
                                rd_n       = dec_rd;
                                regRead1_n = dec_rs;
                                regRead2_n = dec_rt;
                                ALUOp_n    = dec_alu_op;
                                buffCtrl_n = BUFF_ALU;
                            end
                            KIND_MOVI: begin
                                state_n      = ST_WRITE;
                                regWrite_n   = dec_rd;
                                initialR_n   = dec_imm;
                                ALUOp_n      = ALU_AND;
                                buffCtrl_n   = BUFF_IMM;
                                regWriteEn_n = 1'b1;
                            end
                            KIND_HALT: begin
                                state_n   = ST_HALTED;
                                retired_n = retired + RETIRE_W'(1);
                            end
                        endcase
                    end
                end
            end
            ST_READ: begin
                state_n    = ST_EXEC;
                cnt_n      = CNT_W'(EXEC_CYCLES - 1);
                buffCtrl_n = BUFF_ALU;
            end
            ST_EXEC: begin
                buffCtrl_n = BUFF_ALU;
                if (cnt == '0) begin
                    state_n      = ST_WRITE;
                    regWrite_n   = rd_q;
                    regWriteEn_n = 1'b1;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            ST_WRITE: begin
                state_n   = ST_IDLE;
                retired_n = retired + RETIRE_W'(1);
            end
            ST_HALTED: begin
                if (resume) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        instr_ready_n = (state_n == ST_IDLE);
        halted_n      = (state_n == ST_HALTED);
    end

    // State, counters and output registers; reset aborts any in-flight instruction
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            rd_q        <= '0;
            instr_ready <= 1'b0;
            initialR    <= '0;
            regWrite    <= '0;
            regRead1    <= '0;
            regRead2    <= '0;
            ALUOp       <= '0;
            buffCtrl    <= '0;
            regWriteEn  <= 1'b0;
            halted      <= 1'b0;
            illegal     <= 1'b0;
            retired     <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            rd_q        <= rd_n;
            instr_ready <= instr_ready_n;
            initialR    <= initialR_n;
            regWrite    <= regWrite_n;
            regRead1    <= regRead1_n;
            regRead2    <= regRead2_n;
            ALUOp       <= ALUOp_n;
            buffCtrl    <= buffCtrl_n;
            regWriteEn  <= regWriteEn_n;
            halted      <= halted_n;
            illegal     <= illegal_n;
            retired     <= retired_n;
        end
    end

endmodule
